// File: rtl/fetch_cycle.sv
`default_nettype none
//==========================================================================
// fetch_cycle : single-outstanding instruction fetch into a 2-entry
//               {Instruction, PC} FIFO; FETCH_PERF_CNT_EN adds counters.
// Revision    : 1.0
//==========================================================================
module fetch_cycle #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_INC   = 32'd4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_valid,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic [1:0]  PC_Src,
  input  logic [31:0] jumpAddress,
  input  logic [31:0] branchAddress,
  input  logic [31:0] retAddress,
  output logic [31:0] Instruction,
  output logic [31:0] PC,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0] fetch_count,
  output logic [31:0] flush_count,
`endif
  output logic        inst_valid
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    WAIT_RSP = 2'd1,
    DROP     = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] issued_pc_q, issued_pc_d;
  logic        stale_q, stale_d;
  logic        head_q, head_d;
  logic [1:0]  count_q, count_d;
  logic [31:0] inst_q [2];
  logic [31:0] pc_q   [2];

  logic        w_redirect;
  logic [31:0] w_target;
  logic        w_pop;
  logic        w_push;
  logic        w_rsp;
  logic        w_accept;
  logic        w_tail;
  logic [1:0]  w_occ;

  assign inst_valid  = (count_q != 2'd0);
  assign Instruction = inst_q[head_q];
  assign PC          = pc_q[head_q];

  assign w_redirect = (PC_Src != 2'b00);
  assign w_pop      = inst_valid & ~stall;
  assign w_occ      = count_q - 2'(w_pop);
  // A response owed to a request abandoned by reset is swallowed here.
  assign w_rsp      = imem_valid & ~stale_q;
  assign w_push     = (state_q == WAIT_RSP) & w_rsp & ~w_redirect;
  assign w_tail     = head_q ^ count_q[0];

  assign imem_req   = ~rst & (state_q == RUN) & ~w_redirect & (w_occ < 2'd2);
  assign imem_addr  = fetch_pc_q;
  assign w_accept   = imem_req & imem_ready;

  always_comb begin
    w_target = fetch_pc_q;
    unique case (PC_Src)
      2'b01:   w_target = jumpAddress;
      2'b10:   w_target = branchAddress;
      2'b11:   w_target = retAddress;
      default: w_target = fetch_pc_q;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    issued_pc_d = issued_pc_q;
    stale_d     = stale_q & ~imem_valid;
    head_d      = head_q;
    count_d     = count_q;

    if (w_redirect) begin
      fetch_pc_d = w_target;
      head_d     = 1'b0;
      count_d    = 2'd0;
    end else begin
      head_d  = head_q ^ w_pop;
      count_d = count_q + 2'(w_push) - 2'(w_pop);
      if (w_accept) begin
        fetch_pc_d  = fetch_pc_q + PC_INC;
        issued_pc_d = fetch_pc_q;
      end
    end

    unique case (state_q)
      RUN:      if (w_accept) state_d = WAIT_RSP;
      WAIT_RSP: begin
        if (w_rsp)           state_d = RUN;
        else if (w_redirect) state_d = DROP;
      end
      DROP:     if (w_rsp) state_d = RUN;
      default:  state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RUN;
      fetch_pc_q <= RESET_PC;
      head_q     <= 1'b0;
      count_q    <= 2'd0;
      // Remember that a response is still owed if we abandon a request now.
      stale_q    <= (stale_q | (state_q != RUN)) & ~imem_valid;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      issued_pc_q <= issued_pc_d;
      stale_q     <= stale_d;
      head_q      <= head_d;
      count_q     <= count_d;
      if (w_push) begin
        inst_q[w_tail] <= imem_rdata;
        pc_q[w_tail]   <= issued_pc_q;
      end
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_q;
  logic [31:0] flush_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt_q <= 32'd0;
      flush_cnt_q <= 32'd0;
    end else begin
      fetch_cnt_q <= fetch_cnt_q + 32'(w_push);
      flush_cnt_q <= flush_cnt_q + 32'(w_redirect);
    end
  end

  assign fetch_count = fetch_cnt_q;
  assign flush_count = flush_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_cycle.sv
`default_nettype none
//==========================================================================
// tb_fetch_cycle : directed + random checks of fetch_cycle against a
//                  transaction-level model (in-flight list + entry queue).
// Revision       : 1.0
//==========================================================================
module tb_fetch_cycle;

  localparam logic [31:0] RESET_PC_A = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_B = 32'hFFFF_FFFC;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1, stall = 1'b0, imem_ready = 1'b0, imem_valid = 1'b0;
  logic [1:0]  PC_Src = 2'b00;
  logic [31:0] jumpAddress = '0, branchAddress = '0, retAddress = '0, imem_rdata = '0;
  logic        imem_req, inst_valid;
  logic [31:0] imem_addr, Instruction, PC;
  logic        b_req, b_inst_valid;
  logic        b_valid = 1'b0;
  logic [31:0] b_addr, b_inst, b_pc;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_count, flush_count, b_fetch_count, b_flush_count;
`endif

  fetch_cycle #(.RESET_PC(RESET_PC_A), .PC_INC(32'd4)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_valid(imem_valid), .imem_rdata(imem_rdata),
    .stall(stall), .PC_Src(PC_Src), .jumpAddress(jumpAddress),
    .branchAddress(branchAddress), .retAddress(retAddress),
    .Instruction(Instruction), .PC(PC),
`ifdef FETCH_PERF_CNT_EN
    .fetch_count(fetch_count), .flush_count(flush_count),
`endif
    .inst_valid(inst_valid)
  );

  fetch_cycle #(.RESET_PC(RESET_PC_B), .PC_INC(32'd4)) dut_b (
    .clk(clk), .rst(rst), .imem_req(b_req), .imem_addr(b_addr),
    .imem_ready(imem_ready), .imem_valid(b_valid), .imem_rdata(32'h0000_0013),
    .stall(stall), .PC_Src(PC_Src), .jumpAddress(jumpAddress),
    .branchAddress(branchAddress), .retAddress(retAddress),
    .Instruction(b_inst), .PC(b_pc),
`ifdef FETCH_PERF_CNT_EN
    .fetch_count(b_fetch_count), .flush_count(b_flush_count),
`endif
    .inst_valid(b_inst_valid)
  );

  // In-flight memory transactions: wanted = will be presented, blocking =
  // counts as this epoch's single outstanding request.
  typedef struct { logic [31:0] addr; logic [31:0] data; int due; bit wanted; bit blocking; } txn_t;
  typedef struct { logic [31:0] pc; logic [31:0] inst; } ent_t;

  txn_t        infl[$];
  ent_t        mq[$];
  logic [31:0] m_pc = RESET_PC_A;
  int unsigned m_fetch = 0, m_flush = 0;
  int          cyc = 0, lat_min = 1, lat_max = 1;
  int          checks = 0, errors = 0;
  bit          b_pend = 1'b0;
  logic [31:0] acc_log[$], pop_log[$], b_acc_log[$];
  int          first_req_cyc = -1, first_valid_cyc = -1;
  bit          obs_req, obs_valid;
  logic [31:0] obs_addr, obs_pc;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h cycle=%0d", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] qget(input logic [31:0] q[$], input int i);
    return (i < q.size()) ? q[i] : 32'hDEAD_BEEF;
  endfunction

  task automatic step(input bit r, input bit s, input logic [1:0] src, input bit rdy);
    bit          resp, redir, pop, exp_valid, exp_req, blk, b_now;
    logic [31:0] tgt;
    txn_t        t;
    int          due;
    rst = r; stall = s; PC_Src = src; imem_ready = rdy;
    resp       = (infl.size() > 0) && (infl[0].due <= cyc);
    imem_valid = resp;
    imem_rdata = resp ? infl[0].data : $urandom;
    b_valid    = b_pend;
    #1;
    redir     = (src != 2'b00);
    tgt       = (src == 2'b01) ? jumpAddress : (src == 2'b10) ? branchAddress : retAddress;
    exp_valid = (mq.size() != 0);
    pop       = exp_valid && !s;
    blk       = 1'b0;
    foreach (infl[i]) if (infl[i].blocking) blk = 1'b1;
    exp_req   = !r && !redir && !blk && ((mq.size() - (pop ? 1 : 0)) < 2);

    chk("inst_valid", 32'(inst_valid), 32'(exp_valid));
    if (exp_valid) begin
      chk("PC", PC, mq[0].pc);
      chk("Instruction", Instruction, mq[0].inst);
    end
    chk("imem_req", 32'(imem_req), 32'(exp_req));
    if (exp_req) chk("imem_addr", imem_addr, m_pc);
`ifdef FETCH_PERF_CNT_EN
    chk("fetch_count", fetch_count, m_fetch);
    chk("flush_count", flush_count, m_flush);
`endif
    obs_req = imem_req; obs_valid = inst_valid; obs_addr = imem_addr; obs_pc = PC;
    if (imem_req && rdy) begin
      acc_log.push_back(imem_addr);
      if (first_req_cyc < 0) first_req_cyc = cyc;
    end
    if (inst_valid && !s) pop_log.push_back(PC);
    if (inst_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
    b_now = b_req;
    if (b_req && rdy) b_acc_log.push_back(b_addr);

    @(posedge clk);
    if (resp) t = infl.pop_front();
    if (r) begin
      foreach (infl[i]) begin infl[i].wanted = 1'b0; infl[i].blocking = 1'b0; end
      mq.delete();
      m_pc = RESET_PC_A; m_fetch = 0; m_flush = 0;
    end else begin
      if (pop) mq.delete(0);
      if (redir) begin
        mq.delete();
        foreach (infl[i]) infl[i].wanted = 1'b0;
        m_pc = tgt;
        m_flush++;
      end else begin
        if (resp && t.wanted) begin
          mq.push_back('{pc: t.addr, inst: t.data});
          m_fetch++;
        end
        if (exp_req && rdy) begin
          due = cyc + int'($urandom_range(lat_max, lat_min));
          if (infl.size() > 0 && infl[$].due >= due) due = infl[$].due + 1;
          infl.push_back('{addr: m_pc, data: $urandom, due: due, wanted: 1'b1, blocking: 1'b1});
          m_pc = m_pc + 32'd4;
        end
      end
    end
    b_pend = b_now && rdy && !r;
    cyc++;
    @(negedge clk);
  endtask

  function automatic bit own_pending(input int min_ahead, input bit exact);
    if (infl.size() != 1 || !infl[0].wanted || !infl[0].blocking) return 1'b0;
    return exact ? (infl[0].due == cyc) : (infl[0].due > cyc + min_ahead);
  endfunction

  initial begin
    bit found;
    int rel_cyc;
    repeat (2) @(negedge clk);

    // Reset, then streaming memory with single-cycle latency.
    lat_min = 1; lat_max = 1;
    repeat (3) step(1'b1, 1'b0, 2'b00, 1'b1);
    acc_log.delete(); pop_log.delete(); b_acc_log.delete();
    first_req_cyc = -1; first_valid_cyc = -1; rel_cyc = cyc;
    repeat (12) step(1'b0, 1'b0, 2'b00, 1'b1);
    chk("first_req_cycle", 32'(first_req_cyc - rel_cyc), 32'd0);
    chk("req_addr0", qget(acc_log, 0), 32'h0000_0000);
    chk("req_addr1", qget(acc_log, 1), 32'h0000_0004);
    chk("req_addr2", qget(acc_log, 2), 32'h0000_0008);
    chk("latency", 32'(first_valid_cyc - first_req_cyc), 32'd2);
    chk("pc_order0", qget(pop_log, 0), 32'h0000_0000);
    chk("pc_order1", qget(pop_log, 1), 32'h0000_0004);
    chk("pc_order2", qget(pop_log, 2), 32'h0000_0008);
    chk("wrap_req0", qget(b_acc_log, 0), 32'hFFFF_FFFC);
    chk("wrap_req1", qget(b_acc_log, 1), 32'h0000_0000);

    // Decode stalls: FIFO fills, requests stop, nothing lost afterwards.
    repeat (5) step(1'b0, 1'b1, 2'b00, 1'b1);
    chk("stall_req_off", 32'(obs_req), 32'd0);
    chk("stall_fifo_full", 32'(obs_valid), 32'd1);
    repeat (8) step(1'b0, 1'b0, 2'b00, 1'b1);

    // Jump while a response is outstanding.
    lat_min = 3; lat_max = 3;
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      if (own_pending(0, 1'b0)) found = 1'b1; else step(1'b0, 1'b0, 2'b00, 1'b1);
    end
    chk("reach_wait_jump", 32'(found), 32'd1);
    jumpAddress = 32'h1000_0000;
    step(1'b0, 1'b0, 2'b01, 1'b1);
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      step(1'b0, 1'b0, 2'b00, 1'b1);
      if (obs_req) found = 1'b1;
    end
    chk("jump_req_seen", 32'(found), 32'd1);
    chk("jump_req_addr", obs_addr, 32'h1000_0000);
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      step(1'b0, 1'b0, 2'b00, 1'b1);
      if (obs_valid) found = 1'b1;
    end
    chk("jump_valid_seen", 32'(found), 32'd1);
    chk("jump_first_pc", obs_pc, 32'h1000_0000);

    // Branch in the same cycle as the response.
    lat_min = 2; lat_max = 2;
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      if (own_pending(0, 1'b1)) found = 1'b1; else step(1'b0, 1'b0, 2'b00, 1'b1);
    end
    chk("reach_rsp_branch", 32'(found), 32'd1);
    branchAddress = 32'h2000_0040;
    step(1'b0, 1'b0, 2'b10, 1'b1);
    step(1'b0, 1'b0, 2'b00, 1'b1);
    chk("branch_fifo_empty", 32'(obs_valid), 32'd0);
    chk("branch_req", 32'(obs_req), 32'd1);
    chk("branch_req_addr", obs_addr, 32'h2000_0040);

    // Reset while waiting, stale response arrives after release.
    lat_min = 4; lat_max = 4;
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      if (own_pending(1, 1'b0)) found = 1'b1; else step(1'b0, 1'b0, 2'b00, 1'b1);
    end
    chk("reach_wait_rst", 32'(found), 32'd1);
    step(1'b1, 1'b0, 2'b00, 1'b1);
    found = 1'b0;
    for (int k = 0; k < 30 && !found; k++) begin
      step(1'b0, 1'b0, 2'b00, 1'b1);
      if (obs_valid) found = 1'b1;
    end
    chk("rst_valid_seen", 32'(found), 32'd1);
    chk("rst_first_pc", obs_pc, RESET_PC_A);

    // Random traffic against the model.
    lat_min = 1; lat_max = 3;
    for (int n = 0; n < 3000; n++) begin
      bit          r, s, rdy, stale_free;
      logic [1:0]  src;
      stale_free = 1'b1;
      foreach (infl[i]) if (!infl[i].blocking) stale_free = 1'b0;
      r   = stale_free && ($urandom_range(99, 0) == 0);
      s   = ($urandom_range(2, 0) == 0);
      rdy = ($urandom_range(3, 0) != 0);
      src = ($urandom_range(9, 0) == 0) ? 2'($urandom_range(3, 1)) : 2'b00;
      jumpAddress   = $urandom & 32'hFFFF_FFFC;
      branchAddress = ($urandom_range(1, 0) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);
      retAddress    = $urandom & 32'hFFFF_FFFC;
      step(r, s, src, rdy);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fetch_cycle.md
FETCH_CYCLE -- requirements
Module: fetch_cycle

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h00000000, the first fetch address after reset.
REQ-002 The block SHALL have parameter PC_INC, default 4, the sequential PC increment in bytes.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 imem_req  output  1  fetch request valid.
REQ-006 imem_addr  output  32  fetch address; SHALL be held stable while imem_req=1 and imem_ready=0.
REQ-007 imem_ready  input  1  memory accepts the request this cycle.
REQ-008 imem_valid  input  1  response data valid, arriving at least 1 cycle after acceptance.
REQ-009 imem_rdata  input  32  response instruction word.
REQ-010 stall  input  1  decode cannot consume; Instruction/PC SHALL hold.
REQ-011 PC_Src  input  2  next-PC select: 00 sequential, 01 jumpAddress, 10 branchAddress, 11 retAddress.
REQ-012 jumpAddress, branchAddress, retAddress  input  32 each  redirect targets.
REQ-013 Instruction  output  32  instruction word presented to decode.
REQ-014 PC  output  32  address of the presented Instruction.
REQ-015 inst_valid  output  1  Instruction/PC hold a valid entry.

Function
REQ-016 The block SHALL allow at most one outstanding memory request.
REQ-017 Accepted responses SHALL enter a 2-entry FIFO of {Instruction, PC}.
REQ-018 Instruction, PC and inst_valid SHALL be driven combinationally from the FIFO head; inst_valid SHALL equal FIFO non-empty.
REQ-019 The FIFO head SHALL be popped when inst_valid=1 and stall=0.
REQ-020 FSM states SHALL be RUN, WAIT_RSP and DROP.
REQ-021 RUN: imem_req=1 only when FIFO occupancy, counting any entry popped this cycle, is below 2; on imem_ready=1 the FSM SHALL go to WAIT_RSP and fetch_pc SHALL advance by PC_INC.
REQ-022 WAIT_RSP: imem_req=0; on imem_valid=1, {imem_rdata, issued address} SHALL be pushed and the FSM SHALL return to RUN.
REQ-023 DROP: imem_req=0; the next imem_valid SHALL be discarded, and the FSM SHALL then return to RUN.
REQ-024 Redirect is PC_Src!=00, sampled each cycle; its effects SHALL be: FIFO flushed, fetch_pc loaded with the selected target, and no push that cycle.
REQ-025 A redirect SHALL override stall.
REQ-026 A redirect in WAIT_RSP without imem_valid SHALL move the FSM to DROP.
REQ-027 A redirect in the same cycle as imem_valid SHALL discard that response and move the FSM to RUN.
REQ-028 A redirect in RUN SHALL suppress imem_req for that cycle; the target address SHALL be requested the next cycle.
REQ-029 A redirect in DROP SHALL keep the FSM in DROP.
REQ-030 With the FIFO full, no request SHALL be issued; a pop and an issue SHALL be allowed in the same cycle.
REQ-031 fetch_pc SHALL wrap modulo 2^32 (32'hFFFFFFFC + 4 = 0).
REQ-032 Best-case latency SHALL be: request issued and accepted in cycle N, imem_valid in N+1, inst_valid=1 in N+2.

Reset
REQ-033 On rst=1 the block SHALL set: FSM=RUN, FIFO empty, fetch_pc=RESET_PC, inst_valid=0, imem_req=0 during reset.
REQ-034 rst=1 mid-transaction SHALL abandon the outstanding request.
REQ-035 The first imem_valid after reset release SHALL be ignored if a request was outstanding when reset was asserted.
REQ-036 The first request after reset SHALL be issued in the first cycle with rst=0, with imem_addr=RESET_PC.

Configuration
REQ-037 Macro FETCH_PERF_CNT_EN defined: the block SHALL add outputs fetch_count[31:0] (responses pushed) and flush_count[31:0] (redirect cycles).
REQ-038 With FETCH_PERF_CNT_EN defined, both counters SHALL reset to 0 and wrap at 2^32.
REQ-039 Macro FETCH_PERF_CNT_EN undefined: the counter ports and logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-040 Reset release, imem_ready=1, 1-cycle response -> addresses 0,4,8 requested; inst_valid=1 two cycles after first request; PC=0,4,8 in order.
REQ-041 stall=1 for 5 cycles with streaming memory -> FIFO fills to 2; imem_req=0; Instruction/PC held; no words lost after stall drops.
REQ-042 PC_Src=01, jumpAddress=32'h10000000 while in WAIT_RSP -> FSM=DROP; stale response discarded; next request address 32'h10000000; first valid PC=32'h10000000.
REQ-043 PC_Src=10 in the same cycle as imem_valid -> response dropped; FIFO empty; next imem_addr=branchAddress.
REQ-044 RESET_PC=32'hFFFFFFFC -> second request address 32'h00000000.
REQ-045 rst=1 during WAIT_RSP, then a late imem_valid -> the late response is not presented; first presented PC=RESET_PC.
